// File: rtl/imm_extend_pipe_pkg.sv
// Shared definitions for the LEGv8 immediate generator.
// - Format codes carried on opCode.
// - Field LSB/MSB positions within the 32-bit instruction word.
// - ext_imm(): turns a raw, right-aligned field into a 64-bit immediate.
//   Callers narrower than 64 bits keep the low bits, so anything shifted
//   past their MSB is lost.
package imm_extend_pipe_pkg;

   localparam int MAX_W   = 64;
   // The widest raw field is B (26 bits). IW needs 16 + 2 bits.
   localparam int FIELD_W = 26;

   localparam logic [2:0] FMT_D  = 3'b000;
   localparam logic [2:0] FMT_CB = 3'b001;
   localparam logic [2:0] FMT_B  = 3'b010;
   localparam logic [2:0] FMT_I  = 3'b011;
   localparam logic [2:0] FMT_IW = 3'b100;

   localparam int D_LSB     = 12;
   localparam int D_MSB     = 20;
   localparam int CB_LSB    = 5;
   localparam int CB_MSB    = 23;
   localparam int B_LSB     = 0;
   localparam int B_MSB     = 25;
   localparam int I_LSB     = 10;
   localparam int I_MSB     = 21;
   localparam int IW_LSB    = 5;
   localparam int IW_MSB    = 20;
   localparam int IW_HW_MSB = 22;

   localparam int D_W  = D_MSB - D_LSB + 1;
   localparam int CB_W = CB_MSB - CB_LSB + 1;
   localparam int B_W  = B_MSB - B_LSB + 1;
   localparam int I_W  = I_MSB - I_LSB + 1;
   localparam int IW_W = IW_MSB - IW_LSB + 1;

   // Stage-1 payload: raw right-aligned field, its format and the illegal flag.
   typedef struct packed {
      logic [FIELD_W-1:0] field;
      logic [2:0]         fmt;
      logic               illegal;
   } s1_payload_t;

   function automatic logic is_illegal_fmt(input logic [2:0] fmt);
      return fmt > FMT_IW;
   endfunction

   // For IW, field[15:0] holds imm16 and field[17:16] holds hw.
   function automatic logic [MAX_W-1:0] ext_imm(input logic [FIELD_W-1:0] field,
                                                 input logic [2:0]         fmt,
                                                 input logic               shift_branch);
      logic [MAX_W-1:0] v;
      logic [1:0]       hw;
      v  = '0;
      hw = field[IW_W+1:IW_W];
      case (fmt)
         FMT_D:  v = {{(MAX_W-D_W){field[D_W-1]}}, field[D_W-1:0]};
         FMT_CB: begin
            v = {{(MAX_W-CB_W){field[CB_W-1]}}, field[CB_W-1:0]};
            if (shift_branch) v = v << 2;
         end
         FMT_B:  begin
            v = {{(MAX_W-B_W){field[B_W-1]}}, field[B_W-1:0]};
            if (shift_branch) v = v << 2;
         end
         FMT_I:  v = {{(MAX_W-I_W){1'b0}}, field[I_W-1:0]};
         // hw*16 is at most 48, so the shift amount fits in 6 bits.
         FMT_IW: v = {{(MAX_W-IW_W){1'b0}}, field[IW_W-1:0]} << {hw, 4'b0000};
         default: v = '0;
      endcase
      return v;
   endfunction

endpackage

// File: rtl/imm_extend_pipe_if.sv
// Handshake bus of the immediate generator.
// - Input side: in_valid/in_ready, instruction word "in", format select opCode.
// - Output side: out_valid/out_ready, extended immediate "out", out_err.
// - slave: the generator's view. master: the view of whoever drives
//   instructions in and consumes results.
interface imm_extend_pipe_if #(
   parameter int DATA_W  = 64,
   parameter int INSTR_W = 32
);
   logic               in_valid;
   logic               in_ready;
   logic [INSTR_W-1:0] in;
   logic [2:0]         opCode;
   logic               out_valid;
   logic               out_ready;
   logic [DATA_W-1:0]  out;
   logic               out_err;

   modport master (
      output in_valid, in, opCode, out_ready,
      input  in_ready, out_valid, out, out_err
   );

   modport slave (
      input  in_valid, in, opCode, out_ready,
      output in_ready, out_valid, out, out_err
   );
endinterface

// File: rtl/imm_extend_pipe_stage.sv
// imm_pipe_stage: one valid/ready register slice.
// - clk, rst    : clock, asynchronous active-high reset
// - in_valid/in_ready/in_data    : upstream side
// - out_valid/out_ready/out_data : downstream side
// It accepts a new beat whenever it is empty or its current beat leaves in
// the same cycle, so a full pipeline of these slices streams at one beat
// per clock. The data register only loads on an accepted beat, so data
// stays frozen while the consumer stalls.
module imm_pipe_stage #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [W-1:0] in_data,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [W-1:0] out_data
);
   logic         valid_reg;
   logic [W-1:0] data_reg;

   assign in_ready  = !valid_reg || out_ready;
   assign out_valid = valid_reg;
   assign out_data  = data_reg;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         valid_reg <= 1'b0;
         data_reg  <= '0;
      end else if (in_ready) begin
         valid_reg <= in_valid;
         if (in_valid) data_reg <= in_data;
      end
   end
endmodule

// File: rtl/imm_extend_pipe.sv
// imm_extend_pipe: two-stage pipelined LEGv8 immediate generator.
// - clk       : rising-edge clock
// - rst       : asynchronous, active-high reset
// - bus       : handshake bus (slave view): instruction and opCode in,
//               extended immediate and out_err out
// - err_count : saturating count of accepted beats with an illegal opCode
// Stage 1 captures the raw field, the format and the illegal flag. Stage 2
// extends and shifts that field and registers the result. in_ready is
// combinational through both slices from out_ready.
module imm_extend_pipe
   import imm_extend_pipe_pkg::*;
#(
   parameter int DATA_W       = 64,
   parameter int INSTR_W      = 32,
   parameter int SHIFT_BRANCH = 0,
   parameter int ERR_W        = 8
) (
   input  logic              clk,
   input  logic              rst,
   imm_extend_pipe_if.slave  bus,
   output logic [ERR_W-1:0]  err_count
);
   localparam int S2_W = DATA_W + 1;

   s1_payload_t      s1_in;
   s1_payload_t      s1_data;
   logic             s1_valid;
   logic             s2_ready;
   logic [MAX_W-1:0] ext;
   logic [S2_W-1:0]  s2_in;
   logic [S2_W-1:0]  s2_data;
   logic             in_fire;
   logic             unused_instr_bits;

   // Instruction bits above the widest field (B) are never decoded.
   assign unused_instr_bits = ^bus.in[INSTR_W-1:B_MSB+1];

   // Right-align the format's field. IW also keeps hw (in[22:21]) just
   // above imm16 so stage 2 can apply the 16*hw shift.
   always_comb begin
      s1_in         = '0;
      s1_in.fmt     = bus.opCode;
      s1_in.illegal = is_illegal_fmt(bus.opCode);
      case (bus.opCode)
         FMT_D:  s1_in.field[D_W-1:0]  = bus.in[D_MSB:D_LSB];
         FMT_CB: s1_in.field[CB_W-1:0] = bus.in[CB_MSB:CB_LSB];
         FMT_B:  s1_in.field[B_W-1:0]  = bus.in[B_MSB:B_LSB];
         FMT_I:  s1_in.field[I_W-1:0]  = bus.in[I_MSB:I_LSB];
         FMT_IW: s1_in.field[IW_HW_MSB-IW_LSB:0] = bus.in[IW_HW_MSB:IW_LSB];
         default: s1_in.field = '0;
      endcase
   end

   imm_pipe_stage #(.W($bits(s1_payload_t))) u_stage1 (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (bus.in_valid),
      .in_ready  (bus.in_ready),
      .in_data   (s1_in),
      .out_valid (s1_valid),
      .out_ready (s2_ready),
      .out_data  (s1_data)
   );

   // Extension works at 64 bits; keeping the low DATA_W bits both sizes
   // sign extension correctly and zeroes IW shifts at or beyond DATA_W.
   assign ext   = ext_imm(s1_data.field, s1_data.fmt, SHIFT_BRANCH != 0);
   assign s2_in = s1_data.illegal ? {{DATA_W{1'b0}}, 1'b1}
                                  : {ext[DATA_W-1:0], 1'b0};

   imm_pipe_stage #(.W(S2_W)) u_stage2 (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (s1_valid),
      .in_ready  (s2_ready),
      .in_data   (s2_in),
      .out_valid (bus.out_valid),
      .out_ready (bus.out_ready),
      .out_data  (s2_data)
   );

   assign bus.out     = s2_data[S2_W-1:1];
   assign bus.out_err = s2_data[0];

   // Counted when the illegal beat enters stage 1, not when it leaves.
   assign in_fire = bus.in_valid && bus.in_ready;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         err_count <= '0;
      end else if (in_fire && is_illegal_fmt(bus.opCode) && (err_count != {ERR_W{1'b1}})) begin
         err_count <= err_count + 1'b1;
      end
   end
endmodule
